dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the CPU load/store path and a memory loader/debug port used to preload or inspect memory. Each cycle, at most one access is granted and driven onto the memory's write-enable, address and write-data inputs. Read data comes from the memory's asynchronous read port and is returned through a registered response stage. The CPU has default priority; a wait counter guarantees the loader is served.

Parameters:
ADDR_W, 16, address width (memory depth 2^ADDR_W words)
DATA_W, 16, data word width
MAX_WAIT, 4, consecutive cycles the loader may be refused before it is forced to win (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
cpu_req  input  1  CPU access request, held until granted
cpu_we  input  1  1=store, 0=load
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU store data
cpu_gnt  output  1  CPU access performed this cycle (combinational)
cpu_rvalid  output  1  CPU load data valid (registered)
cpu_rdata  output  DATA_W  CPU load data (registered)
ldr_req  input  1  loader access request, held until granted
ldr_we  input  1  1=write, 0=read
ldr_addr  input  ADDR_W  loader word address
ldr_wdata  input  DATA_W  loader write data
ldr_gnt  output  1  loader access performed this cycle (combinational)
ldr_rvalid  output  1  loader read data valid (registered)
ldr_rdata  output  DATA_W  loader read data (registered)
WE_dmem  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory asynchronous read data
ldr_starve  output  1  high while the loader wait counter equals MAX_WAIT (debug/status)

Behaviour:
- Reset (rst=1 at a clk edge): wait_cnt=0, cpu_rvalid=0, ldr_rvalid=0, cpu_rdata=0, ldr_rdata=0. While rst=1, cpu_gnt=ldr_gnt=WE_dmem=0 combinationally, so no write reaches memory.
- Arbitration is combinational, evaluated every cycle:
  - Only one requester asserted: that requester is granted.
  - Both asserted and wait_cnt<MAX_WAIT: CPU granted.
  - Both asserted and wait_cnt==MAX_WAIT: loader granted.
  - Neither asserted: no grant.
- cpu_gnt and ldr_gnt are one-hot or zero; both high is illegal.
- Memory drive:
  - mem_addr/mem_wdata come from the granted requester; the CPU side is selected when there is no grant.
  - WE_dmem = grant & that requester's we.
  - The write commits at the same clk edge as the grant (the memory writes synchronously).
- Read response:
  - When a granted access has we=0, mem_rdata is captured at that edge into the requester's rdata register, and its rvalid=1 for exactly the next cycle.
  - Read latency is 1 cycle from grant.
  - rdata holds its last value when rvalid=0.
  - Write grants produce no rvalid.
- wait_cnt (4-bit, saturating at MAX_WAIT) updates at each edge:
  - ldr_req & !ldr_gnt: increment, saturating at MAX_WAIT.
  - ldr_gnt or !ldr_req: clear to 0.
- Requester rule: a requester keeps req/we/addr/wdata stable until it sees gnt. The arbiter does not latch request fields.
- Back-to-back: a requester may re-assert in the cycle after its grant. Grant and rvalid for different accesses may overlap.
- Same-address write-then-read: a read granted in the cycle after a write to that address returns the new data, because memory is updated at the write edge.
- Reset asserted mid-operation: rvalid pending from the previous edge is cleared at the reset edge; wait_cnt is cleared; no grants while rst=1.
- ldr_starve = (wait_cnt==MAX_WAIT).

Decomposition:
- Shared package dmem_pkg: ADDR_W/DATA_W defaults, and a request struct/typedef (we, addr, wdata) if the flow allows it.
- No sub-module is required.
- Optionally factor a reusable sat_counter (width, max) for wait_cnt; everything else stays inline.

Test Plan:
1. Reset: hold rst=1 with both req=1, cpu_we=1 -> WE_dmem=0, both gnt=0, rvalid=0, rdata=0 throughout.
2. CPU store then load: cpu store addr 0x0010 data 0xBEEF, then load 0x0010 -> cpu_gnt each cycle, WE_dmem=1 only on the store, cpu_rvalid=1 one cycle after the load grant with cpu_rdata=0xBEEF.
3. Loader preload: loader writes 0x1234 to 0x0000..0x0003 back-to-back with the CPU idle -> ldr_gnt 4 consecutive cycles; a subsequent CPU load of 0x0002 returns 0x1234.
4. Contention/starvation: cpu_req and ldr_req (read 0x0020) held continuously, MAX_WAIT=4 -> CPU granted 4 cycles, loader granted on the 5th, ldr_starve high in that cycle, ldr_rvalid the following cycle, wait_cnt back to 0.
5. Simultaneous write/read hazard: loader writes 0x00AA:=0x5555 in cycle N, CPU reads 0x00AA in cycle N+1 -> cpu_rdata=0x5555 with cpu_rvalid in N+2; exactly one grant per cycle.
6. Reset mid-read: CPU load granted, rst=1 on the next edge -> cpu_rvalid=0 after the reset edge, wait_cnt=0, no WE_dmem during reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, the
// wait-counter width and the grant-selection helper.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DATA_W = 16;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_LDR  = 2'd2
  } gnt_sel_e;

  // CPU wins contention unless the loader has been refused long enough.
  function automatic gnt_sel_e arb_pick(input logic cpu_req,
                                        input logic ldr_req,
                                        input logic starve);
    gnt_sel_e sel;
    sel = GNT_NONE;
    if (cpu_req && ldr_req)
      sel = starve ? GNT_LDR : GNT_CPU;
    else if (cpu_req)
      sel = GNT_CPU;
    else if (ldr_req)
      sel = GNT_LDR;
    return sel;
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with clear; clear has priority over increment.
module dmem_arbiter_sat_counter #(
  parameter int          WIDTH = 4,
  parameter int unsigned MAX   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Count refused cycles, hold at MAX, drop to zero on clear or reset.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != MAX_V))
      cnt <= cnt + WIDTH'(1);
  end

  assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory. The CPU has
// default priority; a saturating wait counter forces the loader through
// after MAX_WAIT consecutive refusals. Reads use the memory's async port
// and return through one registered response stage per requester.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int          ADDR_W   = DMEM_ADDR_W,
  parameter int          DATA_W   = DMEM_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              WE_dmem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ldr_starve
);

  gnt_sel_e                sel_p0;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    wait_inc;
  logic                    wait_clr;
  logic                    cpu_rd_p0;
  logic                    ldr_rd_p0;
  logic                    cpu_vld_p1;
  logic                    ldr_vld_p1;
  logic [DATA_W-1:0]       cpu_rdata_p1;
  logic [DATA_W-1:0]       ldr_rdata_p1;

  // Grant selection; nothing is granted while reset is held so no write
  // can reach memory during reset.
  always_comb begin
    sel_p0 = GNT_NONE;
    if (!rst)
      sel_p0 = arb_pick(cpu_req, ldr_req, ldr_starve);
  end

  assign cpu_gnt = (sel_p0 == GNT_CPU);
  assign ldr_gnt = (sel_p0 == GNT_LDR);

  // Memory drive: loader fields only when the loader holds the grant.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (ldr_gnt) begin
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  assign WE_dmem   = (cpu_gnt & cpu_we) | (ldr_gnt & ldr_we);
  assign cpu_rd_p0 = cpu_gnt & ~cpu_we;
  assign ldr_rd_p0 = ldr_gnt & ~ldr_we;

  assign wait_inc = ldr_req & ~ldr_gnt;
  assign wait_clr = ldr_gnt | ~ldr_req;

  dmem_arbiter_sat_counter #(
    .WIDTH (WAIT_CNT_W),
    .MAX   (MAX_WAIT)
  ) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .cnt    (wait_cnt),
    .at_max (ldr_starve)
  );

  // ---- p0 -> p1: read response stage ----
  // Capture async read data for granted loads; rvalid lasts one cycle and
  // rdata holds its last value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_vld_p1   <= 1'b0;
      ldr_vld_p1   <= 1'b0;
      cpu_rdata_p1 <= '0;
      ldr_rdata_p1 <= '0;
    end else begin
      cpu_vld_p1 <= cpu_rd_p0;
      ldr_vld_p1 <= ldr_rd_p0;
      if (cpu_rd_p0)
        cpu_rdata_p1 <= mem_rdata;
      if (ldr_rd_p0)
        ldr_rdata_p1 <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_vld_p1;
  assign cpu_rdata  = cpu_rdata_p1;
  assign ldr_rvalid = ldr_vld_p1;
  assign ldr_rdata  = ldr_rdata_p1;

  // wait_cnt is observable only through ldr_starve.
  logic unused_cnt;
  assign unused_cnt = ^wait_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small sync-write/async-read
// memory model attached to the memory port.
module tb_dmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ldr_req, ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt, ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;
  logic              WE_dmem;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              ldr_starve;

  int errors;
  int checks;

  logic [DATA_W-1:0] mem [0:1023];

  dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .WE_dmem    (WE_dmem),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .ldr_starve (ldr_starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (WE_dmem)
      mem[mem_addr[9:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[9:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic set_ldr(input logic req, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    ldr_req = req; ldr_we = we; ldr_addr = addr; ldr_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;

    // 1: reset with both requesting writes
    set_cpu(1'b1, 1'b1, 16'h0010, 16'hDEAD);
    set_ldr(1'b1, 1'b1, 16'h0011, 16'hDEAD);
    repeat (3) begin
      @(negedge clk);
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_ldr_gnt", 32'(ldr_gnt), 32'd0);
      chk("rst_we", 32'(WE_dmem), 32'd0);
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("rst_ldr_rdata", 32'(ldr_rdata), 32'd0);
      chk("rst_starve", 32'(ldr_starve), 32'd0);
    end
    tick();
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_ldr(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // 2: CPU store then load
    set_cpu(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    chk("st_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("st_ldr_gnt", 32'(ldr_gnt), 32'd0);
    chk("st_we", 32'(WE_dmem), 32'd1);
    chk("st_addr", 32'(mem_addr), 32'h0010);
    chk("st_wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    chk("ld_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("ld_we", 32'(WE_dmem), 32'd0);
    chk("st_no_rvalid", 32'(cpu_rvalid), 32'd0);
    tick();
    set_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("ld_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("ld_rdata", 32'(cpu_rdata), 32'hBEEF);
    tick();
    chk("ld_rvalid_drop", 32'(cpu_rvalid), 32'd0);
    chk("ld_rdata_hold", 32'(cpu_rdata), 32'hBEEF);

    // 3: loader preload 0..3 back-to-back, plus 0x20 for later reads
    for (int i = 0; i < 4; i++) begin
      set_ldr(1'b1, 1'b1, 16'(i), 16'h1234);
      @(negedge clk);
      chk("pre_ldr_gnt", 32'(ldr_gnt), 32'd1);
      chk("pre_we", 32'(WE_dmem), 32'd1);
      chk("pre_addr", 32'(mem_addr), 32'(i));
      tick();
    end
    set_ldr(1'b1, 1'b1, 16'h0020, 16'h0C0C);
    @(negedge clk);
    chk("pre20_ldr_gnt", 32'(ldr_gnt), 32'd1);
    tick();
    chk("pre_no_rvalid", 32'(ldr_rvalid), 32'd0);
    set_ldr(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_cpu(1'b1, 1'b0, 16'h0002, 16'h0000);
    @(negedge clk);
    chk("pre_rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    set_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("pre_rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("pre_rd_rdata", 32'(cpu_rdata), 32'h1234);
    tick();

    // 4: contention, loader forced through on the fifth cycle
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    set_ldr(1'b1, 1'b0, 16'h0020, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("con_cpu_gnt", 32'(cpu_gnt), 32'(k < 4));
      chk("con_ldr_gnt", 32'(ldr_gnt), 32'(k == 4));
      chk("con_starve", 32'(ldr_starve), 32'(k == 4));
      chk("con_addr", 32'(mem_addr), (k < 4) ? 32'h0010 : 32'h0020);
      tick();
      chk("con_cpu_rvalid", 32'(cpu_rvalid), 32'(k < 4));
      chk("con_ldr_rvalid", 32'(ldr_rvalid), 32'(k == 4));
    end
    chk("con_ldr_rdata", 32'(ldr_rdata), 32'h0C0C);
    chk("con_starve_clr", 32'(ldr_starve), 32'd0);
    set_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_ldr(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    chk("con_ldr_rvalid_drop", 32'(ldr_rvalid), 32'd0);

    // 5: loader write then CPU read of the same address next cycle
    set_ldr(1'b1, 1'b1, 16'h00AA, 16'h5555);
    @(negedge clk);
    chk("haz_w_ldr_gnt", 32'(ldr_gnt), 32'd1);
    chk("haz_w_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("haz_w_we", 32'(WE_dmem), 32'd1);
    tick();
    set_ldr(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_cpu(1'b1, 1'b0, 16'h00AA, 16'h0000);
    @(negedge clk);
    chk("haz_r_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("haz_r_ldr_gnt", 32'(ldr_gnt), 32'd0);
    tick();
    set_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("haz_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("haz_rdata", 32'(cpu_rdata), 32'h5555);
    tick();

    // 6: reset after a granted load, with the wait counter part-way up
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    set_ldr(1'b1, 1'b0, 16'h0020, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      chk("mr_cpu_gnt", 32'(cpu_gnt), 32'd1);
      tick();
    end
    rst = 1'b1;
    set_cpu(1'b1, 1'b1, 16'h0010, 16'hDEAD);
    set_ldr(1'b1, 1'b1, 16'h0010, 16'hDEAD);
    chk("mr_pending_rvalid", 32'(cpu_rvalid), 32'd1);
    @(negedge clk);
    chk("mr_cpu_gnt_rst", 32'(cpu_gnt), 32'd0);
    chk("mr_ldr_gnt_rst", 32'(ldr_gnt), 32'd0);
    chk("mr_we_rst", 32'(WE_dmem), 32'd0);
    tick();
    chk("mr_rvalid_clr", 32'(cpu_rvalid), 32'd0);
    chk("mr_rdata_clr", 32'(cpu_rdata), 32'd0);
    chk("mr_starve_clr", 32'(ldr_starve), 32'd0);
    rst = 1'b0;
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    set_ldr(1'b1, 1'b0, 16'h0020, 16'h0000);
    repeat (2) begin
      @(negedge clk);
      chk("post_cpu_gnt", 32'(cpu_gnt), 32'd1);
      chk("post_starve", 32'(ldr_starve), 32'd0);
      tick();
    end
    set_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_ldr(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("post_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("post_rdata_no_rst_write", 32'(cpu_rdata), 32'hBEEF);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
